rvfi_mem_serializer: RTL
========================

# rvfi_mem_serializer

Merges the memory fields of up to NRET RVFI retirement channels into one in-order transaction stream for single-channel memory checkers and shadow-memory models. Instructions retiring without memory access are dropped. A retirement counter tags each transaction with a check-enable bit covering a configurable retirement window. The block sits between the core's RVFI outputs and downstream memory checkers. It never back-pressures the core; FIFO overflow is flagged instead.

## Interface
- XLEN, 32, data/address width (32 or 64)
- NRET, 2, RVFI retirement channels per cycle (1..4)
- DEPTH, 8, FIFO entries; power of two, DEPTH >= NRET
- EN_START, 1, first retirement index (1-based) whose memory transaction is check-enabled
- EN_END, 16, last check-enabled retirement index (inclusive)

Ports:
- clock  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- rvfi_valid  in  NRET  per-channel retire strobe
- rvfi_order  in  64*NRET  per-channel instruction index
- rvfi_mem_addr  in  XLEN*NRET  per-channel address
- rvfi_mem_rmask  in  XLEN/8*NRET  per-channel read byte mask
- rvfi_mem_wmask  in  XLEN/8*NRET  per-channel write byte mask
- rvfi_mem_rdata  in  XLEN*NRET  per-channel read data
- rvfi_mem_wdata  in  XLEN*NRET  per-channel write data
- out_valid  out  1  transaction available
- out_ready  in  1  consumer accepts the transaction this cycle
- out_order, out_addr, out_rmask, out_wmask, out_rdata, out_wdata  out  64/XLEN/XLEN/8/XLEN/8/XLEN/XLEN  head transaction fields
- out_enable  out  1  head transaction lies inside the enable window
- overflow  out  1  sticky; at least one memory transaction was dropped
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Memory entry: rvfi_valid[c] high and (rmask | wmask) nonzero for channel c.
- Each cycle, all memory entries are enqueued in ascending channel index.
- Retirement counter R (32 bit, saturating) advances by popcount(rvfi_valid) per cycle, whether or not an entry has memory access.
- Retirement index of channel c = R + (number of valid channels with index <= c).
- out_enable is high when EN_START <= index <= EN_END. It is computed at enqueue and stored with the entry.
- Space check uses the start-of-cycle occupancy. A same-cycle dequeue does not free a slot.
- If the memory-entry count exceeds DEPTH - level, drop all of that cycle's entries and set overflow. This is all-or-nothing. R still advances.
- Dequeue on out_valid && out_ready. Output fields hold stable while out_valid && !out_ready.
- Channel bit slices follow RVFI packing: channel c occupies [c*W +: W].

## Timing
- Enqueue-to-out_valid latency is 1 cycle: an entry written at edge N is visible after edge N.
- Back-to-back throughput is one transaction per cycle with out_ready held high.
- Reset values: out_valid 0, level 0, overflow 0, R 0, pointers 0. out_* data fields are don't-care but are cleared to 0.
- Reset mid-stream discards all queued entries. RVFI inputs sampled in the reset cycle are ignored.
- Full FIFO with simultaneous dequeue and an incoming entry: the entry is dropped (conservative check) and overflow is set.
- Pointer wrap at DEPTH uses an extra MSB to distinguish full from empty.
- R saturates at 2^32-1 and does not wrap.
- EN_START > EN_END gives out_enable 0 for every transaction.

## Structure
- Shared header/package `rvfi_mem_pkg` holds:
  - the transaction record layout (order, addr, rmask, wmask, rdata, wdata, enable)
  - its packed width constant
  - the popcount and prefix-count functions
- One natural sub-module: `rvfi_mem_mwfifo`, a multi-write (NRET ports), single-read FIFO carrying packed records, with level output.
- The top level contains the retirement counter, entry selection and compaction, and the overflow flag.

## Test plan
- **NRET=2, single load:** channel 1 valid with rmask=4'hF at addr 0x100, channel 0 idle. Next cycle: out_valid=1, out_addr=0x100, out_enable=1 (index 1). level=1 until out_ready.
- **Same-cycle ordering:** both channels are stores, ch0 at 0x10 and ch1 at 0x20, with out_ready=1. Out stream is 0x10 then 0x20 on consecutive cycles, with out_order matching the inputs.
- **Non-memory retirements:** 20 cycles of non-memory retirement on both channels (R=40), then one load. The load is emitted with out_enable=0 (index 41 > EN_END=16). No earlier out_valid.
- **Overflow:** out_ready=0, 3 cycles of dual stores (6 entries, DEPTH=8), then a dual store with level=6, which fits and gives level=8. The next single store is dropped, overflow=1, level stays 8, and the first 8 entries drain intact.
- **Full with simultaneous dequeue:** level=8, out_ready=1, one new load arrives. The load is dropped, overflow=1, level=7.
- **Reset mid-stream:** level=5, resetn=0 for 1 cycle. Afterwards out_valid=0, level=0, overflow=0, and the next retirement gets index 1.

Source files
------------

// File: rtl/rvfi_mem_pkg.sv
// Shared definitions for the RVFI memory serializer: record sizing and the
// channel-counting helpers used for compaction and retirement indexing.
package rvfi_mem_pkg;

  localparam int ORDER_W  = 64;
  localparam int MAX_NRET = 4;

  // Record layout: {order, addr, rmask, wmask, rdata, wdata, enable}, MSB first.
  function automatic int rec_width(input int xlen);
    return ORDER_W + 3 * xlen + 2 * (xlen / 8) + 1;
  endfunction

  function automatic logic [2:0] popcount(input logic [MAX_NRET-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < MAX_NRET; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Number of set bits strictly below position upto.
  function automatic logic [2:0] prefix_count(input logic [MAX_NRET-1:0] v, input int upto);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < MAX_NRET; i++) begin
      if (i < upto) n = n + {2'b00, v[i]};
      else          n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/rvfi_mem_serializer_if.sv
// RVFI retirement inputs and the serialized memory-transaction stream.
interface rvfi_mem_serializer_if #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
);
  localparam int MW = XLEN / 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [XLEN*NRET-1:0] rvfi_mem_addr;
  logic [MW*NRET-1:0]   rvfi_mem_rmask;
  logic [MW*NRET-1:0]   rvfi_mem_wmask;
  logic [XLEN*NRET-1:0] rvfi_mem_rdata;
  logic [XLEN*NRET-1:0] rvfi_mem_wdata;

  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_order;
  logic [XLEN-1:0]      out_addr;
  logic [MW-1:0]        out_rmask;
  logic [MW-1:0]        out_wmask;
  logic [XLEN-1:0]      out_rdata;
  logic [XLEN-1:0]      out_wdata;
  logic                 out_enable;
  logic                 overflow;
  logic [LW-1:0]        level;

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
           rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
    output out_valid, out_order, out_addr, out_rmask, out_wmask, out_rdata,
           out_wdata, out_enable, overflow, level
  );

  modport master (
    output rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
           rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
    input  out_valid, out_order, out_addr, out_rmask, out_wmask, out_rdata,
           out_wdata, out_enable, overflow, level
  );
endinterface

// File: rtl/rvfi_mem_serializer_mwfifo.sv
// Multi-write, single-read FIFO: up to NWR compacted records per cycle,
// slot 0 first; pointers carry an extra MSB to tell full from empty.
module rvfi_mem_mwfifo #(
  parameter int WIDTH = 8,
  parameter int NWR   = 2,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NWR-1:0][WIDTH-1:0] wr_data,
  input  logic [2:0]                wr_cnt,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic [AW:0]               level
);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW-1:0]    wr_idx_s [NWR];

  // Storage slot for each write port, wrapping at DEPTH.
  always_comb begin
    for (int i = 0; i < NWR; i++) begin
      wr_idx_s[i] = wr_ptr_r[AW-1:0] + AW'(i);
    end
  end

  // Storage and pointer update; the caller guarantees wr_cnt fits.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int d = 0; d < DEPTH; d++) mem_r[d] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (3'(i) < wr_cnt) mem_r[wr_idx_s[i]] <= wr_data[i];
      end
      wr_ptr_r <= wr_ptr_r + (AW+1)'(wr_cnt);
      if (rd_en && rd_valid) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  assign level    = wr_ptr_r - rd_ptr_r;
  assign rd_valid = (level != '0);
  assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/rvfi_mem_serializer.sv
// Merges per-channel RVFI memory accesses into one in-order stream, tagging each
// with a retirement-window enable; never stalls the core, flags overflow instead.
module rvfi_mem_serializer
  import rvfi_mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NRET     = 2,
  parameter int DEPTH    = 8,
  parameter int EN_START = 1,
  parameter int EN_END   = 16
) (
  input logic                  clock,
  input logic                  resetn,
  rvfi_mem_serializer_if.slave bus
);
  localparam int MW = XLEN / 8;
  localparam int RW = rec_width(XLEN);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] addr;
    logic [MW-1:0]   rmask;
    logic [MW-1:0]   wmask;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;
    logic            enable;
  } rec_t;

  logic [31:0]               ret_cnt_r;
  logic                      overflow_r;
  logic [MAX_NRET-1:0]       valid_pad_s;
  logic [MAX_NRET-1:0]       mem_pad_s;
  logic [2:0]                mem_cnt_s;
  logic [2:0]                wr_cnt_s;
  logic [2:0]                ret_inc_s;
  logic                      fits_s;
  logic [32:0]               ret_sum_s;
  logic [33:0]               ret_idx_s;
  rec_t                      chan_rec_s;
  logic [NRET-1:0][RW-1:0]   wr_data_s;
  logic [RW-1:0]             head_s;
  rec_t                      head_rec_s;
  logic [LW-1:0]             level_s;
  logic                      head_valid_s;

  // Memory-entry detection and the all-or-nothing space check on start-of-cycle level.
  always_comb begin
    valid_pad_s = '0;
    mem_pad_s   = '0;
    for (int c = 0; c < NRET; c++) begin
      valid_pad_s[c] = bus.rvfi_valid[c];
      mem_pad_s[c]   = bus.rvfi_valid[c] &
                       (|(bus.rvfi_mem_rmask[c*MW +: MW] | bus.rvfi_mem_wmask[c*MW +: MW]));
    end
    mem_cnt_s = popcount(mem_pad_s);
    ret_inc_s = popcount(valid_pad_s);
    fits_s    = (int'(mem_cnt_s) <= (DEPTH - int'(level_s)));
    wr_cnt_s  = fits_s ? mem_cnt_s : 3'd0;
    ret_sum_s = {1'b0, ret_cnt_r} + {30'd0, ret_inc_s};
  end

  // Build each channel's record and compact memory entries into ascending write slots.
  always_comb begin
    wr_data_s  = '0;
    chan_rec_s = '0;
    ret_idx_s  = '0;
    for (int c = 0; c < NRET; c++) begin
      ret_idx_s         = {2'b00, ret_cnt_r} + {31'd0, prefix_count(valid_pad_s, c + 1)};
      chan_rec_s.order  = bus.rvfi_order[c*64 +: 64];
      chan_rec_s.addr   = bus.rvfi_mem_addr[c*XLEN +: XLEN];
      chan_rec_s.rmask  = bus.rvfi_mem_rmask[c*MW +: MW];
      chan_rec_s.wmask  = bus.rvfi_mem_wmask[c*MW +: MW];
      chan_rec_s.rdata  = bus.rvfi_mem_rdata[c*XLEN +: XLEN];
      chan_rec_s.wdata  = bus.rvfi_mem_wdata[c*XLEN +: XLEN];
      chan_rec_s.enable = (ret_idx_s >= 34'(EN_START)) && (ret_idx_s <= 34'(EN_END));
      for (int s = 0; s < NRET; s++) begin
        if (mem_pad_s[c] && (prefix_count(mem_pad_s, c) == 3'(s))) wr_data_s[s] = chan_rec_s;
        else                                                       wr_data_s[s] = wr_data_s[s];
      end
    end
  end

  // Saturating retirement counter and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ret_cnt_r  <= 32'd0;
      overflow_r <= 1'b0;
    end else begin
      ret_cnt_r  <= ret_sum_s[32] ? 32'hFFFF_FFFF : ret_sum_s[31:0];
      overflow_r <= overflow_r | ~fits_s;
    end
  end

  rvfi_mem_mwfifo #(
    .WIDTH (RW),
    .NWR   (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .wr_data  (wr_data_s),
    .wr_cnt   (wr_cnt_s),
    .rd_en    (bus.out_ready),
    .rd_data  (head_s),
    .rd_valid (head_valid_s),
    .level    (level_s)
  );

  assign head_rec_s     = rec_t'(head_s);
  assign bus.out_valid  = head_valid_s;
  assign bus.out_order  = head_rec_s.order;
  assign bus.out_addr   = head_rec_s.addr;
  assign bus.out_rmask  = head_rec_s.rmask;
  assign bus.out_wmask  = head_rec_s.wmask;
  assign bus.out_rdata  = head_rec_s.rdata;
  assign bus.out_wdata  = head_rec_s.wdata;
  assign bus.out_enable = head_rec_s.enable;
  assign bus.overflow   = overflow_r;
  assign bus.level      = level_s;

endmodule
